// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing one UART transmitter among N byte
// sources. Towards the UART it looks like a single FIFO (tx_empty/tx_data,
// tx_start as pop); each start is routed back as a pop to the granted source.
// Optional line lock: define TX_ARB_LINE_LOCK_EN to keep a grant until the
// EOL byte is sent or the locked source stays empty for LOCK_TIMEOUT cycles.
module tx_arbiter #(
  parameter int          N            = 4,
  parameter logic [7:0]  EOL          = 8'h0A,
  parameter int          LOCK_TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_empty,
  input  logic [N*8-1:0] req_data,
  output logic [N-1:0]   req_pop,
  output logic           tx_empty,
  output logic [7:0]     tx_data,
  input  logic           tx_start,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] gidx;
  logic [IW-1:0] nxt;

`ifdef TX_ARB_LINE_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  // First non-empty index scanning upward from ptr+1, wrapping modulo N.
  // Scanning in reverse makes the nearest candidate the final assignment.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] empty,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    int            idx;
    sel = ptr;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (!empty[idx[IW-1:0]]) sel = idx[IW-1:0];
    end
    return sel;
  endfunction

  assign nxt  = rr_pick(req_empty, last);
  assign busy = |grant;

  // Steer the granted source to the UART; pops are suppressed during reset
  // so a start coincident with rst never consumes a byte.
  always_comb begin
    tx_empty = 1'b1;
    tx_data  = '0;
    req_pop  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        tx_empty   = req_empty[i];
        tx_data    = req_data[8*i +: 8];
        req_pop[i] = tx_start & ~rst;
      end
    end
  end

  // Arbitration FSM: grant is only ever loaded in IDLE and only cleared on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= LAST_RST;
`ifdef TX_ARB_LINE_LOCK_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef TX_ARB_LINE_LOCK_EN
          cnt <= '0;
`endif
          if (!(&req_empty)) begin
            gidx  <= nxt;
            grant <= ONE << nxt;
            state <= GRANT;
          end
        end
        GRANT: begin
`ifdef TX_ARB_LINE_LOCK_EN
          if (tx_start) begin
            cnt <= '0;
            if (tx_data == EOL) begin
              state <= IDLE;
              grant <= '0;
              last  <= gidx;
            end
          end else if (req_empty[gidx]) begin
            // Release on the edge where the idle count reaches LOCK_TIMEOUT.
            if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
              cnt   <= '0;
              state <= IDLE;
              grant <= '0;
              last  <= gidx;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
`else
          if (tx_start) begin
            state <= IDLE;
            grant <= '0;
            last  <= gidx;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter with four modelled source
// FIFOs and a simple UART model that starts whenever a byte is presented.
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_empty;
  logic [31:0] req_data;
  logic [3:0]  req_pop;
  logic        tx_empty;
  logic [7:0]  tx_data;
  logic        tx_start = 1'b0;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // source FIFO model
  logic [7:0] mem [4][16];
  int         rd [4];
  int         wr [4];
  logic       clr = 1'b0;

  // captured UART traffic
  logic [7:0] log_b   [32];
  logic [3:0] log_g   [32];
  logic [3:0] log_p   [32];
  int         log_gap [32];
  int         nl = 0;

  tx_arbiter #(.N(4), .EOL(8'h0A), .LOCK_TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_empty(req_empty),
    .req_data (req_data),
    .req_pop  (req_pop),
    .tx_empty (tx_empty),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_empty = '1;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      req_empty[i]        = (rd[i] == wr[i]);
      req_data[8*i +: 8]  = mem[i][rd[i] % 16];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (clr) rd[i] <= 0;
      else if (req_pop[i]) rd[i] <= rd[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int s, input logic [7:0] b);
    mem[s][wr[s] % 16] = b;
    wr[s] = wr[s] + 1;
  endtask

  // Reset DUT and empty all source FIFOs; returns just after a negedge with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr = 1'b1;
    tx_start = 1'b0;
    for (int i = 0; i < 4; i++) wr[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    nl = 0;
  endtask

  // UART model: start on every presented byte until n bytes are taken.
  task automatic collect(input int n, input int budget);
    int cyc;
    int gap;
    cyc = 0;
    gap = 0;
    while (n > 0 && cyc < budget) begin
      @(negedge clk);
      tx_start = 1'b0;
      #1;
      cyc++;
      if (!tx_empty) begin
        tx_start = 1'b1;
        #1;
        log_b[nl]   = tx_data;
        log_g[nl]   = grant;
        log_p[nl]   = req_pop;
        log_gap[nl] = gap;
        nl++;
        gap = 0;
        n--;
      end else begin
        gap++;
      end
    end
    chk("collect_budget", n, 0);
    @(negedge clk);
    tx_start = 1'b0;
    #1;
  endtask

  task automatic expect_byte(input int idx, input logic [7:0] b, input int src);
    logic [3:0] oh;
    oh = 4'b0001 << src;
    chk($sformatf("byte%0d", idx), log_b[idx], b);
    chk($sformatf("grant%0d", idx), log_g[idx], oh);
    chk($sformatf("pop%0d", idx), log_p[idx], oh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0;
      for (int k = 0; k < 16; k++) mem[i][k] = 8'h00;
    end

    // reset values (tx_start held high to confirm no pop under reset)
    clr = 1'b1;
    repeat (2) @(negedge clk);
    tx_start = 1'b1;
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_req_pop", req_pop, 4'b0000);
    tx_start = 1'b0;
    do_reset();

`ifndef TX_ARB_LINE_LOCK_EN
    // single source 2 with three bytes
    load(2, 8'h41); load(2, 8'h42); load(2, 8'h43);
    #1;
    chk("t1_idle_empty", tx_empty, 1'b1);
    @(negedge clk); #1;
    chk("t1_grant_t1", grant, 4'b0100);
    chk("t1_busy", busy, 1'b1);
    chk("t1_present_empty", tx_empty, 1'b0);
    chk("t1_present_data", tx_data, 8'h41);
    collect(3, 20);
    chk("t1_count", nl, 3);
    expect_byte(0, 8'h41, 2);
    expect_byte(1, 8'h42, 2);
    expect_byte(2, 8'h43, 2);
    chk("t1_gap1", log_gap[1], 1);
    chk("t1_gap2", log_gap[2], 1);
    chk("t1_grant_end", grant, 4'b0000);
    chk("t1_busy_end", busy, 1'b0);

    // fairness: all four sources, two bytes each
    do_reset();
    for (int s = 0; s < 4; s++) begin
      load(s, 8'hA0 + 8'(s * 16));
      load(s, 8'hA1 + 8'(s * 16));
    end
    collect(8, 60);
    for (int j = 0; j < 8; j++) begin
      expect_byte(j, 8'hA0 + 8'((j % 4) * 16) + 8'(j / 4), j % 4);
      if (j > 0) chk($sformatf("t2_gap%0d", j), log_gap[j], 1);
    end

    // tx_start while idle: pointer set to 1 first, then an idle pulse
    nl = 0;
    load(1, 8'h77);
    collect(1, 10);
    expect_byte(0, 8'h77, 1);
    tx_start = 1'b1;
    #1;
    chk("t3_idle_pop", req_pop, 4'b0000);
    chk("t3_idle_grant", grant, 4'b0000);
    @(negedge clk);
    tx_start = 1'b0;
    #1;
    chk("t3_after_grant", grant, 4'b0000);
    chk("t3_after_empty", tx_empty, 1'b1);
    load(0, 8'h50); load(2, 8'h52);
    @(negedge clk); #1;
    chk("t3_rr_from_last", grant, 4'b0100);
    nl = 0;
    collect(2, 10);
    expect_byte(0, 8'h52, 2);
    expect_byte(1, 8'h50, 0);

    // reset while source 3 is granted with its byte pending
    load(3, 8'h33);
    @(negedge clk); #1;
    chk("t4_grant3", grant, 4'b1000);
    chk("t4_data3", tx_data, 8'h33);
    rst = 1'b1;
    tx_start = 1'b1;
    #1;
    chk("t4_pop_in_rst", req_pop, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tx_start = 1'b0;
    #1;
    chk("t4_grant_dropped", grant, 4'b0000);
    chk("t4_busy_dropped", busy, 1'b0);
    chk("t4_src3_kept", wr[3] - rd[3], 1);
    load(0, 8'h05);
    @(negedge clk); #1;
    chk("t4_restart_at_0", grant, 4'b0001);
    nl = 0;
    collect(2, 10);
    expect_byte(0, 8'h05, 0);
    expect_byte(1, 8'h33, 3);
`else
    // line lock: two concurrent lines must not interleave
    load(0, 8'h41); load(0, 8'h42); load(0, 8'h0A);
    load(1, 8'h78); load(1, 8'h79); load(1, 8'h0A);
    collect(6, 40);
    expect_byte(0, 8'h41, 0);
    expect_byte(1, 8'h42, 0);
    expect_byte(2, 8'h0A, 0);
    expect_byte(3, 8'h78, 1);
    expect_byte(4, 8'h79, 1);
    expect_byte(5, 8'h0A, 1);
    chk("lk_inline_gap", log_gap[1], 0);
    chk("lk_idle_end", grant, 4'b0000);

    // line lock timeout: source 0 sends "AB" and goes empty, source 1 waits
    do_reset();
    load(0, 8'h41); load(0, 8'h42);
    load(1, 8'h5A);
    collect(2, 20);
    expect_byte(0, 8'h41, 0);
    expect_byte(1, 8'h42, 0);
    chk("to_locked_1", grant, 4'b0001);
    repeat (15) @(negedge clk);
    #1;
    chk("to_locked_16", grant, 4'b0001);
    chk("to_locked_empty", tx_empty, 1'b1);
    @(negedge clk); #1;
    chk("to_released", grant, 4'b0000);
    @(negedge clk); #1;
    chk("to_next_src1", grant, 4'b0010);
    chk("to_next_data", tx_data, 8'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
